// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, trap/return flush sequencing,
// PC redirect steering and a sticky stall watchdog.
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int WDT_W        = 8
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              stallreq_if_i,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              stallreq_mem_i,
    input  logic              branch_redirect_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              exception_i,
    input  logic [ADDR_W-1:0] trap_vector_i,
    input  logic              mret_i,
    input  logic [ADDR_W-1:0] epc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              new_pc_valid_o,
    output logic [ADDR_W-1:0] new_pc_o,
    output logic              wdt_timeout_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WDT_W-1:0] WDT_MAX = '1;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] last_pc_q;
    logic [WDT_W-1:0]  wdt_q, wdt_d;
    logic              wdt_to_q;
    logic [5:0]        stall_run;

    always_comb begin
        stall_run = 6'b000000;
        priority case (1'b1)
            stallreq_mem_i: stall_run = 6'b011111;
            stallreq_ex_i:  stall_run = 6'b001111;
            stallreq_id_i:  stall_run = 6'b000111;
            stallreq_if_i:  stall_run = 6'b000011;
            default:        stall_run = 6'b000000;
        endcase
    end

    // Combinational outputs are gated by reset so an async reset
    // mid-flush drops everything at once, not at the next edge.
    always_comb begin
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        tgt_d          = tgt_q;
        stall_o        = 6'b000000;
        flush_o        = 1'b0;
        new_pc_valid_o = 1'b0;
        new_pc_o       = last_pc_q;
        if (n_rst_i) begin
            unique case (state_q)
                RUN: begin
                    stall_o = stall_run;
                    if (branch_redirect_i) begin
                        new_pc_valid_o = 1'b1;
                        new_pc_o       = branch_target_i;
                    end
                    if ((exception_i || mret_i) && !stallreq_mem_i) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                        tgt_d   = exception_i ? trap_vector_i : epc_i;
                    end
                end
                FLUSH: begin
                    flush_o = 1'b1;
                    if (fcnt_q == FLUSH_LOAD) begin
                        new_pc_valid_o = 1'b1;
                        new_pc_o       = tgt_q;
                    end
                    fcnt_d = fcnt_q - CNT_ONE;
                    if (fcnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        wdt_d = '0;
        if (state_q == RUN && stall_o != 6'b000000) begin
            wdt_d = (wdt_q == WDT_MAX) ? wdt_q : wdt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q   <= RUN;
            fcnt_q    <= '0;
            tgt_q     <= '0;
            last_pc_q <= '0;
            wdt_q     <= '0;
            wdt_to_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tgt_q   <= tgt_d;
            wdt_q   <= wdt_d;
            if (wdt_d == WDT_MAX) begin
                wdt_to_q <= 1'b1;
            end
            if (new_pc_valid_o) begin
                last_pc_q <= new_pc_o;
            end
        end
    end

    assign wdt_timeout_o = wdt_to_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed cycles push expected
// outputs, a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        stallreq_if_i, stallreq_id_i;
    logic        stallreq_ex_i, stallreq_mem_i;
    logic        branch_redirect_i;
    logic [31:0] branch_target_i;
    logic        exception_i;
    logic [31:0] trap_vector_i;
    logic        mret_i;
    logic [31:0] epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;
    logic        wdt_timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [5:0]  st;
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic        w;
    } exp_t;

    exp_t sb[$];

    pipe_ctrl #(
        .ADDR_W(32),
        .FLUSH_CYCLES(2),
        .WDT_W(4)
    ) dut (
        .clk_i(clk_i),
        .n_rst_i(n_rst_i),
        .stallreq_if_i(stallreq_if_i),
        .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i),
        .branch_redirect_i(branch_redirect_i),
        .branch_target_i(branch_target_i),
        .exception_i(exception_i),
        .trap_vector_i(trap_vector_i),
        .mret_i(mret_i),
        .epc_i(epc_i),
        .stall_o(stall_o),
        .flush_o(flush_o),
        .new_pc_valid_o(new_pc_valid_o),
        .new_pc_o(new_pc_o),
        .wdt_timeout_o(wdt_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({stall_o, flush_o, new_pc_valid_o, new_pc_o, wdt_timeout_o}
                !== {e.st, e.fl, e.v, e.pc, e.w}) begin
                errors++;
                $display("FAIL %s: got st=%b fl=%b v=%b pc=%h w=%b, want st=%b fl=%b v=%b pc=%h w=%b",
                         e.nm, stall_o, flush_o, new_pc_valid_o, new_pc_o,
                         wdt_timeout_o, e.st, e.fl, e.v, e.pc, e.w);
            end
        end
    end

    task automatic cyc(input string nm, input logic [5:0] st,
                       input logic fl, input logic v,
                       input logic [31:0] pc, input logic w);
        exp_t e;
        e.nm = nm;
        e.st = st;
        e.fl = fl;
        e.v  = v;
        e.pc = pc;
        e.w  = w;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        stallreq_if_i     = 1'b0;
        stallreq_id_i     = 1'b0;
        stallreq_ex_i     = 1'b0;
        stallreq_mem_i    = 1'b0;
        branch_redirect_i = 1'b0;
        exception_i       = 1'b0;
        mret_i            = 1'b0;
    endtask

    initial begin
        n_rst_i         = 1'b0;
        branch_target_i = '0;
        trap_vector_i   = '0;
        epc_i           = '0;
        clr();
        @(posedge clk_i);
        #1;

        // reset gates live requests
        stallreq_if_i     = 1'b1;
        branch_redirect_i = 1'b1;
        branch_target_i   = 32'h0000_0100;
        cyc("reset", 6'b000000, 0, 0, 32'h0, 0);
        clr();
        n_rst_i = 1'b1;
        cyc("idle", 6'b000000, 0, 0, 32'h0, 0);

        stallreq_if_i = 1'b1;
        stallreq_ex_i = 1'b1;
        cyc("if_ex", 6'b001111, 0, 0, 32'h0, 0);
        stallreq_ex_i = 1'b0;
        cyc("if_only", 6'b000011, 0, 0, 32'h0, 0);
        stallreq_if_i = 1'b0;
        stallreq_id_i = 1'b1;
        cyc("id_only", 6'b000111, 0, 0, 32'h0, 0);
        stallreq_if_i  = 1'b1;
        stallreq_ex_i  = 1'b1;
        stallreq_mem_i = 1'b1;
        cyc("mem_all", 6'b011111, 0, 0, 32'h0, 0);
        clr();
        cyc("none", 6'b000000, 0, 0, 32'h0, 0);

        branch_redirect_i = 1'b1;
        branch_target_i   = 32'h0000_0100;
        cyc("branch", 6'b000000, 0, 1, 32'h0000_0100, 0);
        branch_redirect_i = 1'b0;
        branch_target_i   = 32'h0000_0200;
        cyc("br_hold", 6'b000000, 0, 0, 32'h0000_0100, 0);

        exception_i   = 1'b1;
        trap_vector_i = 32'h8000_0000;
        cyc("exc_acc", 6'b000000, 0, 0, 32'h0000_0100, 0);
        clr();
        stallreq_mem_i    = 1'b1;
        branch_redirect_i = 1'b1;
        branch_target_i   = 32'h0000_0300;
        cyc("exc_f1", 6'b000000, 1, 1, 32'h8000_0000, 0);
        cyc("exc_f2", 6'b000000, 1, 0, 32'h8000_0000, 0);
        clr();
        exception_i   = 1'b1;
        trap_vector_i = 32'h8000_0040;
        cyc("b2b_acc", 6'b000000, 0, 0, 32'h8000_0000, 0);
        clr();
        cyc("b2b_f1", 6'b000000, 1, 1, 32'h8000_0040, 0);
        cyc("b2b_f2", 6'b000000, 1, 0, 32'h8000_0040, 0);
        cyc("b2b_run", 6'b000000, 0, 0, 32'h8000_0040, 0);

        exception_i    = 1'b1;
        mret_i         = 1'b1;
        stallreq_mem_i = 1'b1;
        trap_vector_i  = 32'h8000_0000;
        epc_i          = 32'h0000_1234;
        for (int i = 0; i < 3; i++)
            cyc("holdoff", 6'b011111, 0, 0, 32'h8000_0040, 0);
        stallreq_mem_i = 1'b0;
        cyc("hold_rel", 6'b000000, 0, 0, 32'h8000_0040, 0);
        clr();
        cyc("hold_f1", 6'b000000, 1, 1, 32'h8000_0000, 0);
        cyc("hold_f2", 6'b000000, 1, 0, 32'h8000_0000, 0);
        cyc("hold_run", 6'b000000, 0, 0, 32'h8000_0000, 0);

        mret_i = 1'b1;
        cyc("mret_acc", 6'b000000, 0, 0, 32'h8000_0000, 0);
        clr();
        cyc("mret_f1", 6'b000000, 1, 1, 32'h0000_1234, 0);
        cyc("mret_f2", 6'b000000, 1, 0, 32'h0000_1234, 0);
        cyc("mret_run", 6'b000000, 0, 0, 32'h0000_1234, 0);

        branch_redirect_i = 1'b1;
        branch_target_i   = 32'h0000_0500;
        exception_i       = 1'b1;
        cyc("br_trap", 6'b000000, 0, 1, 32'h0000_0500, 0);
        clr();
        cyc("br_trap_f1", 6'b000000, 1, 1, 32'h8000_0000, 0);
        cyc("br_trap_f2", 6'b000000, 1, 0, 32'h8000_0000, 0);
        cyc("br_trap_run", 6'b000000, 0, 0, 32'h8000_0000, 0);

        stallreq_id_i = 1'b1;
        for (int i = 0; i < 15; i++)
            cyc("wdt_cnt", 6'b000111, 0, 0, 32'h8000_0000, 0);
        clr();
        cyc("wdt_set", 6'b000000, 0, 0, 32'h8000_0000, 1);
        cyc("wdt_sticky", 6'b000000, 0, 0, 32'h8000_0000, 1);

        exception_i = 1'b1;
        cyc("rst_acc", 6'b000000, 0, 0, 32'h8000_0000, 1);
        clr();
        cyc("rst_f1", 6'b000000, 1, 1, 32'h8000_0000, 1);
        n_rst_i = 1'b0;
        cyc("rst_mid", 6'b000000, 0, 0, 32'h0, 0);
        n_rst_i = 1'b1;
        cyc("rst_run", 6'b000000, 0, 0, 32'h0, 0);
        stallreq_id_i = 1'b1;
        cyc("rst_stall", 6'b000111, 0, 0, 32'h0, 0);
        clr();

        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk_i);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges per-stage stall requests into the 6-bit `stall_o` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences multi-cycle flushes on traps and `mret`, and steers PC redirects from EX branches and from trap/return events. A stall watchdog flags a pipeline that stays stalled for too long.

## Interface

Parameters:

- `ADDR_W`, 32, PC width.
- `FLUSH_CYCLES`, 2, cycles `flush_o` is held per trap/return (≥1).
- `WDT_W`, 8, width of the consecutive-stall watchdog counter.

Ports:

- `clk_i` in 1: clock. All logic is on the rising edge.
- `n_rst_i` in 1: asynchronous active-low reset.
- `stallreq_if_i` in 1: IF waiting on instruction memory.
- `stallreq_id_i` in 1: load-use hazard.
- `stallreq_ex_i` in 1: multi-cycle EX op (mul/div) busy.
- `stallreq_mem_i` in 1: data bus wait.
- `branch_redirect_i` in 1: EX resolved a mispredict.
- `branch_target_i` in ADDR_W: correct PC for the redirect.
- `exception_i` in 1: MEM-stage instruction traps.
- `trap_vector_i` in ADDR_W: handler address (mtvec).
- `mret_i` in 1: MEM-stage `mret`.
- `epc_i` in ADDR_W: return address (mepc).
- `stall_o` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = STOP.
- `flush_o` out 1: squash IF/ID, ID/EX and EX/MEM contents.
- `new_pc_valid_o` out 1: PC must load `new_pc_o` this cycle.
- `new_pc_o` out ADDR_W: redirect target.
- `wdt_timeout_o` out 1: sticky stall-watchdog flag.

## Operation

- **States:** RUN, FLUSH. Reset enters RUN.
- **Stall merge in RUN** (combinational). The deepest requester wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- **Trap acceptance (RUN only).**
  - `exception_i` or `mret_i` is accepted only when `stallreq_mem_i`=0. Otherwise it is held off until MEM releases.
  - If both are asserted, exception wins.
  - On acceptance: latch the target (`trap_vector_i`, or `epc_i` for `mret`), load the flush counter with FLUSH_CYCLES, and go to FLUSH at the next edge.
- **FLUSH state.**
  - `flush_o`=1 and `stall_o`=0 throughout; all requests are ignored.
  - `new_pc_valid_o`=1 with the latched target on the first FLUSH cycle only.
  - The counter decrements each cycle; the state returns to RUN after the FLUSH_CYCLES-th cycle.
  - `branch_redirect_i`, `exception_i` and `mret_i` are ignored, since they come from squashed instructions.
- **Branch redirect in RUN** (combinational, same cycle):
  - `new_pc_valid_o`=1 and `new_pc_o`=`branch_target_i`.
  - No stall or flush is produced; the IF/ID register handles its own squash on redirect.
- **Redirect vs. trap in the same RUN cycle:** the branch redirect is still driven that cycle. The trap is accepted and overrides it on the next cycle via FLUSH.
- **Watchdog.**
  - The counter increments each RUN cycle with `stall_o`≠0 and clears on any cycle with `stall_o`=0 or in FLUSH.
  - It saturates at 2^WDT_W−1.
  - Reaching saturation sets `wdt_timeout_o`, which stays set until reset.
- **Idle `new_pc_o`:** holds its last driven value when `new_pc_valid_o`=0.

## Timing

- **Reset (async, while `n_rst_i`=0):**
  - `stall_o`=0, `flush_o`=0, `new_pc_valid_o`=0.
  - `new_pc_o`=0, `wdt_timeout_o`=0.
  - State RUN, counters 0.
- **Reset mid-FLUSH:** FLUSH is abandoned immediately and no redirect is issued.
- **Latencies:**
  - Stall request → `stall_o`: 0 cycles.
  - Branch redirect → `new_pc_valid_o`: 0 cycles.
  - Accepted trap at edge N → `flush_o` and `new_pc_valid_o` in cycle N+1. `flush_o` stays high through cycle N+FLUSH_CYCLES; RUN resumes in cycle N+FLUSH_CYCLES+1.
- **Back-to-back:** an exception presented in the first RUN cycle after FLUSH is accepted normally.
- **Watchdog:** `wdt_timeout_o` rises on the edge where the counter reaches 2^WDT_W−1, i.e. after 255 consecutive stalled cycles at default WDT_W.

## Test plan

- **Stall priority:** `stallreq_if_i`=1 and `stallreq_ex_i`=1 together → `stall_o`=6'b001111 in the same cycle. Drop ex → 6'b000011.
- **Branch redirect:** `branch_redirect_i`=1, target 0x0000_0100 → same cycle `new_pc_valid_o`=1, `new_pc_o`=0x100, `flush_o`=0. Next cycle valid=0.
- **Exception flush:** `exception_i`=1, `trap_vector_i`=0x8000_0000 at edge N →
  - cycle N+1: `flush_o`=1, `new_pc_valid_o`=1, `new_pc_o`=0x8000_0000.
  - cycle N+2: `flush_o`=1, valid=0.
  - cycle N+3: `flush_o`=0.
- **Holdoff and priority:**
  - `exception_i` and `mret_i` with `stallreq_mem_i`=1 for 3 cycles → no flush, `stall_o`=6'b011111.
  - MEM releases → flush on the next cycle, target = `trap_vector_i` (not `epc_i`).
  - A `branch_redirect_i` during FLUSH → no `new_pc_valid_o`.
- **Watchdog:** WDT_W=4, hold `stallreq_id_i` → `wdt_timeout_o` rises after 15 stalled cycles and stays high after the stall drops. Only `n_rst_i` low clears it.
- **Async reset mid-FLUSH:** assert `n_rst_i`=0 between edges during FLUSH → `flush_o`=0 immediately, all outputs at reset values. After release, state is RUN.
